mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single processor-memory port between fetch (icache miss loads) and the dcache/LSQ
//  (loads and stores). Grants one requester per cycle and forwards memory's transaction tag to
//  the winner. Records the owner of every outstanding load tag and routes each returning data
//  tag to that owner only. Sits between fetch/dcache and the top-level proc2mem/mem2proc bus.
// PARAMETERS
//  NUM_MEM_TAGS  `NUM_MEM_TAGS  memory transaction tags; tag 0 = none/rejected
//  STARVE_LIMIT  4              consecutive fetch losses before fetch is forced to win
// PORTS
//  clock             in   1             clock
//  reset             in   1             reset, synchronous, active-high
//  br_task           in   BR_TASK       SQUASH drops fetch-owned outstanding tags
//  fetch_req         in   1             fetch wants a load
//  fetch_addr        in   ADDR          fetch load address (8B aligned)
//  fetch_grant       out  1             port given to fetch this cycle (fetch arbiter_signal)
//  fetch_trans_tag   out  MEM_TAG       accepted tag for fetch, else 0
//  fetch_data_tag    out  MEM_TAG       returning tag owned by fetch, else 0
//  dc_req            in   1             dcache wants the port
//  dc_cmd            in   MEM_COMMAND   MEM_LOAD or MEM_STORE
//  dc_addr           in   ADDR          dcache address
//  dc_wdata          in   MEM_BLOCK     store data
//  dc_grant          out  1             port given to dcache this cycle
//  dc_trans_tag      out  MEM_TAG       accepted tag for dcache, else 0
//  dc_data_tag       out  MEM_TAG       returning tag owned by dcache, else 0
//  proc2mem_command  out  MEM_COMMAND   MEM_NONE when no grant
//  proc2mem_addr     out  ADDR          granted address, 0 when idle
//  proc2mem_data     out  MEM_BLOCK     dc_wdata on granted store, else 0
//  mem2proc_transaction_tag in MEM_TAG  tag for this cycle's command, 0 = rejected
//  mem2proc_data_tag in   MEM_TAG       completing tag, 0 = none
//  mem2proc_data     out-of-band: consumers read the bus directly; not routed here
// BEHAVIOUR
//  - Grant logic combinational, same cycle as request. At most one of fetch_grant/dc_grant high.
//  - Default priority: dcache over fetch, except when starve_cnt == STARVE_LIMIT and fetch_req:
//    fetch wins.
//  - starve_cnt (reg, $clog2(STARVE_LIMIT+1) bits): +1 when fetch_req & ~fetch_grant, saturates
//    at STARVE_LIMIT; cleared when fetch_grant and trans_tag != 0, when ~fetch_req, or on reset.
//  - Tag forwarding: winner's *_trans_tag = mem2proc_transaction_tag; loser's = 0. A tag of 0
//    means rejected: the requester retries next cycle, no table update, and the grant does not
//    clear starve_cnt.
//  - Owner table: own_valid[NUM_MEM_TAGS:1], own_fetch[NUM_MEM_TAGS:1]. Accepted LOAD (tag != 0)
//    sets valid and sets own_fetch = (winner == fetch) at that tag on the next edge. Stores are
//    never recorded.
//  - Response routing, combinational: if mem2proc_data_tag != 0 & own_valid[tag], drive it on
//    fetch_data_tag or dc_data_tag per own_fetch; clear the entry next edge. Unknown or invalid
//    tag: both outputs 0, dropped.
//  - Same-cycle alloc and free of the same tag: alloc wins (entry valid with new owner).
//  - br_task == SQUASH: next edge clears every valid entry with own_fetch = 1; dcache entries
//    kept. Same-cycle fetch alloc is not recorded; a same-cycle fetch response is still routed.
//  - Reset: table cleared, starve_cnt = 0. Reset outputs: grants 0, all tags 0,
//    proc2mem_command = MEM_NONE, addr/data 0 (no requests are honoured while reset is high).
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: starvation counter removed; 1-bit last_winner register; on
//  contention, the requester that did not win the last accepted grant wins; reset last_winner =
//  dcache (fetch wins first tie). Undefined: fixed dcache priority plus STARVE_LIMIT as above.
// TESTING
//  1 fetch_req only, addr 0x100, mem tag 3 -> fetch_grant=1, cmd LOAD, fetch_trans_tag=3;
//    later data_tag 3 -> fetch_data_tag=3, dc_data_tag=0, entry 3 cleared.
//  2 both req, mem tag 5 -> dc_grant=1, dc_trans_tag=5, fetch_trans_tag=0; after 4 lost cycles
//    the 5th grants fetch (default build).
//  3 dc STORE addr 0x40 data 0xDEAD, tag 7 -> proc2mem_data=0xDEAD, no table entry;
//    data_tag 7 -> both data tags 0.
//  4 fetch load tag 2, dc load tag 4 outstanding, SQUASH -> data_tag 2 dropped,
//    data_tag 4 -> dc_data_tag=4.
//  5 mem tag 0 on grant -> trans tags 0, no entry, starve_cnt not cleared; retry accepted next
//    cycle.
//  6 reset asserted mid-traffic with 3 entries valid -> table empty, all outputs at reset values
//    next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the proc2mem port between fetch and dcache, tracks load-tag owners and routes responses.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces the fetch starvation counter with round-robin tie breaking.
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_arbiter_pkg;
   localparam int NUM_MEM_TAGS = `NUM_MEM_TAGS;
   typedef logic [$clog2(NUM_MEM_TAGS+1)-1:0] MEM_TAG;
   typedef logic [31:0] ADDR;
   typedef logic [63:0] MEM_BLOCK;
   typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} MEM_COMMAND;
   typedef enum logic {NOTHING, SQUASH} BR_TASK;
endpackage

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  BR_TASK     br_task,
   input  logic       fetch_req,
   input  ADDR        fetch_addr,
   output logic       fetch_grant,
   output MEM_TAG     fetch_trans_tag,
   output MEM_TAG     fetch_data_tag,
   input  logic       dc_req,
   input  MEM_COMMAND dc_cmd,
   input  ADDR        dc_addr,
   input  MEM_BLOCK   dc_wdata,
   output logic       dc_grant,
   output MEM_TAG     dc_trans_tag,
   output MEM_TAG     dc_data_tag,
   output MEM_COMMAND proc2mem_command,
   output ADDR        proc2mem_addr,
   output MEM_BLOCK   proc2mem_data,
   input  MEM_TAG     mem2proc_transaction_tag,
   input  MEM_TAG     mem2proc_data_tag
);
   localparam int N = NUM_MEM_TAGS;
   logic prefer_fetch, accepted, alloc, rsp_hit, squash;
   logic [N:1] own_valid, own_fetch, alloc_mask, free_mask, kill_mask;
   logic [N:0] valid_ext, fetch_ext;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_fetch;
   assign prefer_fetch = ~last_fetch;
   always_ff @(posedge clock) begin
      if (reset)
         last_fetch <= 1'b0;
      else if (accepted)
         last_fetch <= fetch_grant;
   end
`else
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;
   assign prefer_fetch = starve_cnt == SW'(STARVE_LIMIT);
   // A rejected fetch grant holds the count so fetch keeps its forced win for the retry.
   always_ff @(posedge clock) begin
      if (reset || !fetch_req || (fetch_grant && accepted))
         starve_cnt <= '0;
      else if (!fetch_grant && !prefer_fetch)
         starve_cnt <= starve_cnt + 1'b1;
   end
`endif

   assign fetch_grant = !reset && fetch_req && (!dc_req || prefer_fetch);
   assign dc_grant    = !reset && dc_req && !fetch_grant;
   assign accepted    = (fetch_grant || dc_grant) && mem2proc_transaction_tag != '0;
   assign squash      = br_task == SQUASH;
   assign alloc       = accepted && (fetch_grant || dc_cmd == MEM_LOAD) && !(squash && fetch_grant);

   assign fetch_trans_tag  = fetch_grant ? mem2proc_transaction_tag : '0;
   assign dc_trans_tag     = dc_grant ? mem2proc_transaction_tag : '0;
   assign proc2mem_command = fetch_grant ? MEM_LOAD : dc_grant ? dc_cmd : MEM_NONE;
   assign proc2mem_addr    = fetch_grant ? fetch_addr : dc_grant ? dc_addr : '0;
   assign proc2mem_data    = (dc_grant && dc_cmd == MEM_STORE) ? dc_wdata : '0;

   // Bit 0 pads the tables so tag 0 indexes a permanently invalid slot.
   assign valid_ext      = {own_valid, 1'b0};
   assign fetch_ext      = {own_fetch, 1'b0};
   assign rsp_hit        = !reset && valid_ext[mem2proc_data_tag];
   assign fetch_data_tag = (rsp_hit && fetch_ext[mem2proc_data_tag]) ? mem2proc_data_tag : '0;
   assign dc_data_tag    = (rsp_hit && !fetch_ext[mem2proc_data_tag]) ? mem2proc_data_tag : '0;

   always_comb begin
      alloc_mask = '0;
      free_mask  = '0;
      kill_mask  = squash ? own_fetch : '0;
      for (int i = 1; i <= N; i++) begin
         alloc_mask[i] = alloc && mem2proc_transaction_tag == MEM_TAG'(i);
         free_mask[i]  = rsp_hit && mem2proc_data_tag == MEM_TAG'(i);
      end
   end

   // Allocation is applied last so a same-cycle alloc overrides free and squash.
   always_ff @(posedge clock) begin
      if (reset) begin
         own_valid <= '0;
         own_fetch <= '0;
      end else begin
         own_valid <= (own_valid & ~free_mask & ~kill_mask) | alloc_mask;
         own_fetch <= (own_fetch & ~alloc_mask) | (alloc_mask & {N{fetch_grant}});
      end
   end
endmodule
